bp_mem_txn_monitor: RTL and testbench

- Synthesizable, multi-channel memory-transaction monitor that passively observes BedRock memory command and response header handshakes.
- For each channel it tracks outstanding commands, classifies and counts read and write commands, and measures command-to-response latency. Responses are matched in order against a per-channel FIFO of issue timestamps.
- It sits beside the CCE/memory boundary, in the same spot a trace-only monitor would occupy. It exposes statistics and sticky protocol-error flags to the testbench or a debug CSR block.

---
 rtl/bp_mem_txn_monitor.sv | 125 ++++++++++++
 tb/tb_bp_mem_txn_monitor.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_mem_txn_monitor.sv
// Passive per-channel monitor of BedRock mem cmd/resp header handshakes: occupancy, rd/wr counts, latency, sticky errors.
// Define BP_MEM_TXN_MONITOR_TRACE_EN to add simulation-only trace logging.
module bp_mem_txn_monitor #(
  parameter int channels_p   = 2,
  parameter int fifo_els_p   = 8,
  parameter int cnt_width_p  = 32,
  parameter int lat_width_p  = 16,
  parameter int type_width_p = 4
`ifdef BP_MEM_TXN_MONITOR_TRACE_EN
  , parameter string trace_file_p = "mem_mon.trace"
`endif
) (
  input  logic                                       clk_i,
  input  logic                                       reset_i,
  input  logic                                       clear_i,
  input  logic [channels_p-1:0]                      cmd_v_i,
  input  logic [channels_p-1:0]                      cmd_ready_i,
  input  logic [channels_p*type_width_p-1:0]         cmd_type_i,
  input  logic [channels_p-1:0]                      resp_v_i,
  input  logic [channels_p-1:0]                      resp_yumi_i,
  output logic [channels_p*$clog2(fifo_els_p+1)-1:0] outstanding_o,
  output logic [channels_p*cnt_width_p-1:0]          rd_cnt_o,
  output logic [channels_p*cnt_width_p-1:0]          wr_cnt_o,
  output logic [channels_p*lat_width_p-1:0]          last_lat_o,
  output logic [channels_p*lat_width_p-1:0]          max_lat_o,
  output logic [channels_p-1:0]                      lat_v_o,
  output logic [channels_p*2-1:0]                    error_o
);

  localparam int occ_width_lp = $clog2(fifo_els_p+1);
  localparam int ptr_width_lp = $clog2(fifo_els_p);

  logic [lat_width_p-1:0] ts_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) ts_q <= '0;
    else          ts_q <= ts_q + lat_width_p'(1);
  end

  for (genvar gi = 0; gi < channels_p; gi++) begin : g_ch
    logic [lat_width_p-1:0]  mem_q [fifo_els_p];
    logic [ptr_width_lp-1:0] wptr_q, rptr_q;
    logic [occ_width_lp-1:0] count_q, count_d;
    logic [cnt_width_p-1:0]  rd_cnt_q, wr_cnt_q;
    logic [lat_width_p-1:0]  last_lat_q, max_lat_q, lat;
    logic                    lat_v_q;
    logic [1:0]              err_q;
    logic [type_width_p-1:0] cmd_type;
    logic cmd_fire, resp_fire, empty, full, push, pop, ovf, unf, is_rd, is_wr;

    assign cmd_type  = cmd_type_i[gi*type_width_p +: type_width_p];
    assign cmd_fire  = cmd_v_i[gi] & cmd_ready_i[gi];
    assign resp_fire = resp_v_i[gi] & resp_yumi_i[gi];
    assign empty     = (count_q == '0);
    assign full      = (count_q == occ_width_lp'(fifo_els_p));
    assign pop       = resp_fire & ~empty;
    // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
    assign push      = cmd_fire & (~full | pop);
    assign ovf       = cmd_fire & full & ~pop;
    assign unf       = resp_fire & empty;
    assign is_rd     = (cmd_type == type_width_p'(0)) || (cmd_type == type_width_p'(2));
    assign is_wr     = (cmd_type == type_width_p'(1)) || (cmd_type == type_width_p'(3));
    assign lat       = ts_q - mem_q[rptr_q];
    assign count_d   = count_q + occ_width_lp'(push) - occ_width_lp'(pop);

    always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
        for (int i = 0; i < fifo_els_p; i++) mem_q[i] <= '0;
        wptr_q     <= '0;
        rptr_q     <= '0;
        count_q    <= '0;
        rd_cnt_q   <= '0;
        wr_cnt_q   <= '0;
        last_lat_q <= '0;
        max_lat_q  <= '0;
        lat_v_q    <= 1'b0;
        err_q      <= '0;
      end else begin
        if (push) begin
          mem_q[wptr_q] <= ts_q;
          wptr_q        <= wptr_q + ptr_width_lp'(1);
        end
        if (pop) rptr_q <= rptr_q + ptr_width_lp'(1);
        count_q <= count_d;
        lat_v_q <= pop & ~clear_i;
        // Clear wins over same-cycle events for stats; FIFO traffic above is unaffected.
        if (clear_i) begin
          rd_cnt_q   <= '0;
          wr_cnt_q   <= '0;
          last_lat_q <= '0;
          max_lat_q  <= '0;
          err_q      <= '0;
        end else begin
          if (cmd_fire && is_rd && !(&rd_cnt_q)) rd_cnt_q <= rd_cnt_q + cnt_width_p'(1);
          if (cmd_fire && is_wr && !(&wr_cnt_q)) wr_cnt_q <= wr_cnt_q + cnt_width_p'(1);
          if (pop) begin
            last_lat_q <= lat;
            if (lat > max_lat_q) max_lat_q <= lat;
          end
          err_q <= err_q | {unf, ovf};
        end
      end
    end

    assign outstanding_o[gi*occ_width_lp +: occ_width_lp] = count_q;
    assign rd_cnt_o[gi*cnt_width_p +: cnt_width_p]        = rd_cnt_q;
    assign wr_cnt_o[gi*cnt_width_p +: cnt_width_p]        = wr_cnt_q;
    assign last_lat_o[gi*lat_width_p +: lat_width_p]      = last_lat_q;
    assign max_lat_o[gi*lat_width_p +: lat_width_p]       = max_lat_q;
    assign lat_v_o[gi]                                    = lat_v_q;
    assign error_o[gi*2 +: 2]                             = err_q;

`ifdef BP_MEM_TXN_MONITOR_TRACE_EN
    always @(posedge clk_i) begin
      if (reset_i) begin
        if (cmd_fire) $display("%0t ch%0d type=%0d CMD", $time, gi, cmd_type);
        if (pop)      $display("%0t ch%0d lat=%0d RESP", $time, gi, lat);
        if (ovf)      $display("%0t ch%0d ERROR OVF", $time, gi);
        if (unf)      $display("%0t ch%0d ERROR UNF", $time, gi);
      end
    end
`endif
  end

endmodule

// File: tb/tb_bp_mem_txn_monitor.sv
// Bench for bp_mem_txn_monitor: directed vector table, queue-based reference model under random traffic,
// and a narrow-width instance for counter saturation and timestamp wrap.
module tb_bp_mem_txn_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst_s_n;
  logic [1:0] cmd_v, cmd_rdy, resp_v, resp_yumi;
  logic [7:0] cmd_type;
  logic       clr;
  logic [7:0]  outstanding;
  logic [63:0] rd_cnt, wr_cnt;
  logic [31:0] last_lat, max_lat;
  logic [1:0]  lat_v;
  logic [3:0]  err;

  bp_mem_txn_monitor dut (
    .clk_i(clk), .reset_i(rst_n), .clear_i(clr),
    .cmd_v_i(cmd_v), .cmd_ready_i(cmd_rdy), .cmd_type_i(cmd_type),
    .resp_v_i(resp_v), .resp_yumi_i(resp_yumi),
    .outstanding_o(outstanding), .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt),
    .last_lat_o(last_lat), .max_lat_o(max_lat), .lat_v_o(lat_v), .error_o(err)
  );

  // Narrow instance: 4-bit counters and timestamps, 4-deep FIFO.
  logic       s_cmd_v, s_resp_v, s_latv;
  logic [3:0] s_type, s_rd, s_wr, s_last, s_max;
  logic [2:0] s_out;
  logic [1:0] s_err;

  bp_mem_txn_monitor #(.channels_p(1), .fifo_els_p(4), .cnt_width_p(4), .lat_width_p(4), .type_width_p(4)) dut_s (
    .clk_i(clk), .reset_i(rst_s_n), .clear_i(1'b0),
    .cmd_v_i(s_cmd_v), .cmd_ready_i(1'b1), .cmd_type_i(s_type),
    .resp_v_i(s_resp_v), .resp_yumi_i(s_resp_v),
    .outstanding_o(s_out), .rd_cnt_o(s_rd), .wr_cnt_o(s_wr),
    .last_lat_o(s_last), .max_lat_o(s_max), .lat_v_o(s_latv), .error_o(s_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: stamps held in a queue per channel, stats recomputed from the rules.
  int unsigned m_ts;
  int unsigned m_q [2][$];
  int unsigned m_rd [2], m_wr [2], m_last [2], m_max [2];
  bit          m_latv [2];
  logic [1:0]  m_err [2];
  bit          m_cf, m_rf;
  int unsigned m_lat;
  logic [3:0]  m_t;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ts = 0;
      for (int c = 0; c < 2; c++) begin
        m_q[c].delete();
        m_rd[c] = 0; m_wr[c] = 0; m_last[c] = 0; m_max[c] = 0; m_latv[c] = 0; m_err[c] = 2'b00;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        m_cf = cmd_v[c] && cmd_rdy[c];
        m_rf = resp_v[c] && resp_yumi[c];
        m_t  = cmd_type[c*4 +: 4];
        m_latv[c] = 0;
        if (m_rf) begin
          if (m_q[c].size() > 0) begin
            m_lat = (m_ts - m_q[c].pop_front()) % 65536;
            if (!clr) begin
              m_last[c] = m_lat;
              if (m_lat > m_max[c]) m_max[c] = m_lat;
              m_latv[c] = 1;
            end
          end else if (!clr) m_err[c][1] = 1'b1;
        end
        if (m_cf) begin
          if (m_q[c].size() < 8) m_q[c].push_back(m_ts);
          else if (!clr) m_err[c][0] = 1'b1;
          if (!clr && (m_t == 0 || m_t == 2) && m_rd[c] != 32'hFFFF_FFFF) m_rd[c]++;
          if (!clr && (m_t == 1 || m_t == 3) && m_wr[c] != 32'hFFFF_FFFF) m_wr[c]++;
        end
        if (clr) begin
          m_rd[c] = 0; m_wr[c] = 0; m_last[c] = 0; m_max[c] = 0; m_err[c] = 2'b00;
        end
      end
      m_ts = (m_ts + 1) % 65536;
    end
  end

  int unsigned s_ts;
  always @(posedge clk or negedge rst_s_n) begin
    if (!rst_s_n) s_ts = 0;
    else          s_ts = (s_ts + 1) % 16;
  end

  task automatic check_model(input string tag);
    for (int c = 0; c < 2; c++) begin
      chk({tag, "/out"},  64'(outstanding[c*4 +: 4]), 64'(m_q[c].size()));
      chk({tag, "/rd"},   64'(rd_cnt[c*32 +: 32]),    64'(m_rd[c]));
      chk({tag, "/wr"},   64'(wr_cnt[c*32 +: 32]),    64'(m_wr[c]));
      chk({tag, "/last"}, 64'(last_lat[c*16 +: 16]),  64'(m_last[c]));
      chk({tag, "/max"},  64'(max_lat[c*16 +: 16]),   64'(m_max[c]));
      chk({tag, "/latv"}, 64'(lat_v[c]),              64'(m_latv[c]));
      chk({tag, "/err"},  64'(err[c*2 +: 2]),         64'(m_err[c]));
    end
  endtask

  typedef struct {
    logic [1:0]  cmd;
    logic [3:0]  typ;
    logic [1:0]  resp;
    logic        clr;
    logic [3:0]  out0, out1;
    logic [1:0]  latv;
    logic [3:0]  err;
    logic [15:0] last0, last1;
  } vec_t;

  function automatic vec_t mk(int cmd, int typ, int resp, int c, int out0, int out1,
                              int latv, int e, int last0, int last1);
    vec_t v;
    v.cmd = 2'(cmd); v.typ = 4'(typ); v.resp = 2'(resp); v.clr = 1'(c);
    v.out0 = 4'(out0); v.out1 = 4'(out1); v.latv = 2'(latv); v.err = 4'(e);
    v.last0 = 16'(last0); v.last1 = 16'(last1);
    return v;
  endfunction

  vec_t vecs [33];
  int   n;
  bit   found;
  int   pc;

  initial begin
    // Vector table: each row is one cycle; expectations are what the outputs show after that edge.
    n = 0;
    vecs[n++] = mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);          // ch0 rd at T
    for (int i = 0; i < 4; i++) vecs[n++] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    vecs[n++] = mk(0, 0, 1, 0, 0, 0, 1, 0, 5, 0);          // resp at T+5 -> lat 5
    vecs[n++] = mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
    vecs[n++] = mk(2, 1, 0, 0, 0, 1, 0, 0, 5, 0);          // ch1 wr at T'
    vecs[n++] = mk(2, 1, 0, 0, 0, 2, 0, 0, 5, 0);          // ch1 wr at T'+1
    for (int i = 0; i < 2; i++) vecs[n++] = mk(0, 0, 0, 0, 0, 2, 0, 0, 5, 0);
    vecs[n++] = mk(0, 0, 2, 0, 0, 1, 2, 0, 5, 4);          // resp at T'+4 -> 4
    for (int i = 0; i < 5; i++) vecs[n++] = mk(0, 0, 0, 0, 0, 1, 0, 0, 5, 4);
    vecs[n++] = mk(0, 0, 2, 0, 0, 0, 2, 0, 5, 9);          // resp at T'+10 -> 9
    for (int i = 1; i <= 8; i++) vecs[n++] = mk(1, 5, 0, 0, i, 0, 0, 0, 5, 9);
    vecs[n++] = mk(1, 5, 0, 0, 8, 0, 0, 1, 5, 9);          // 9th push -> overflow
    vecs[n++] = mk(1, 5, 1, 0, 8, 0, 1, 1, 9, 9);          // push+pop when full
    vecs[n++] = mk(0, 0, 1, 0, 7, 0, 1, 1, 9, 9);
    vecs[n++] = mk(0, 0, 2, 0, 7, 0, 0, 9, 9, 9);          // ch1 underflow
    vecs[n++] = mk(2, 3, 2, 0, 7, 1, 0, 9, 9, 9);          // push+pop on empty ch1
    vecs[n++] = mk(0, 0, 0, 1, 7, 1, 0, 0, 0, 0);          // clear
    vecs[n++] = mk(0, 0, 0, 0, 7, 1, 0, 0, 0, 0);

    rst_n = 1'b0; rst_s_n = 1'b0;
    cmd_v = '0; cmd_rdy = '0; cmd_type = '0; resp_v = '0; resp_yumi = '0; clr = 1'b0;
    s_cmd_v = 1'b0; s_type = '0; s_resp_v = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1; rst_s_n = 1'b1;
    tick();
    check_model("idle");

    // Reset in the middle of traffic on channel 0.
    cmd_v = 2'b01; cmd_rdy = 2'b01; cmd_type = 8'h00;
    repeat (3) begin tick(); check_model("pre_rst"); end
    chk("pre_rst_out0", 64'(outstanding[3:0]), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out",  64'(outstanding), 64'd0);
    chk("rst_rd",   rd_cnt,           64'd0);
    chk("rst_wr",   wr_cnt,           64'd0);
    chk("rst_last", 64'(last_lat),    64'd0);
    chk("rst_max",  64'(max_lat),     64'd0);
    chk("rst_latv", 64'(lat_v),       64'd0);
    chk("rst_err",  64'(err),         64'd0);
    cmd_v = '0; cmd_rdy = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_out0", 64'(outstanding[3:0]), 64'd0);
    check_model("post_rst");

    for (int i = 0; i < n; i++) begin
      cmd_v = vecs[i].cmd; cmd_rdy = vecs[i].cmd; cmd_type = {vecs[i].typ, vecs[i].typ};
      resp_v = vecs[i].resp; resp_yumi = vecs[i].resp; clr = vecs[i].clr;
      tick();
      $display("vec %0d: out0=%0d out1=%0d latv=%b err=%b last0=%0d last1=%0d",
               i, outstanding[3:0], outstanding[7:4], lat_v, err, last_lat[15:0], last_lat[31:16]);
      chk($sformatf("vec%0d_out0", i),  64'(outstanding[3:0]), 64'(vecs[i].out0));
      chk($sformatf("vec%0d_out1", i),  64'(outstanding[7:4]), 64'(vecs[i].out1));
      chk($sformatf("vec%0d_latv", i),  64'(lat_v),            64'(vecs[i].latv));
      chk($sformatf("vec%0d_err", i),   64'(err),              64'(vecs[i].err));
      chk($sformatf("vec%0d_last0", i), 64'(last_lat[15:0]),   64'(vecs[i].last0));
      chk($sformatf("vec%0d_last1", i), 64'(last_lat[31:16]),  64'(vecs[i].last1));
      check_model($sformatf("vec%0d", i));
      if (i == 17) begin
        chk("inorder_max1", 64'(max_lat[31:16]), 64'd9);
        chk("inorder_wr1",  64'(wr_cnt[63:32]),  64'd2);
        chk("inorder_rd0",  64'(rd_cnt[31:0]),   64'd1);
        chk("inorder_max0", 64'(max_lat[15:0]),  64'd5);
      end
      if (i == 30) begin
        chk("preclr_rd0", 64'(rd_cnt[31:0]),  64'd1);
        chk("preclr_wr0", 64'(wr_cnt[31:0]),  64'd0);
        chk("preclr_wr1", 64'(wr_cnt[63:32]), 64'd3);
        chk("preclr_rd1", 64'(rd_cnt[63:32]), 64'd0);
      end
      if (i == n - 1) begin
        chk("clr_rd",  rd_cnt,           64'd0);
        chk("clr_wr",  wr_cnt,           64'd0);
        chk("clr_max", 64'(max_lat),     64'd0);
      end
    end

    // Random traffic: fill-biased, drain-biased, then balanced.
    for (int ph = 0; ph < 3; ph++) begin
      pc = (ph == 0) ? 70 : (ph == 1) ? 30 : 50;
      for (int k = 0; k < 500; k++) begin
        for (int c = 0; c < 2; c++) begin
          cmd_v[c]     = ($urandom_range(0, 99) < pc);
          cmd_rdy[c]   = ($urandom_range(0, 99) < 75);
          resp_v[c]    = ($urandom_range(0, 99) < (100 - pc));
          resp_yumi[c] = ($urandom_range(0, 99) < 75);
          cmd_type[c*4 +: 4] = 4'($urandom_range(0, 7));
        end
        clr = ($urandom_range(0, 99) < 2);
        tick();
        check_model($sformatf("rand%0d_%0d", ph, k));
      end
      $display("random phase %0d done: out0=%0d out1=%0d err=%b", ph, outstanding[3:0], outstanding[7:4], err);
    end
    cmd_v = '0; cmd_rdy = '0; resp_v = '0; resp_yumi = '0; clr = 1'b0;

    // Narrow instance: read counter saturates at 15.
    s_cmd_v = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_type = (i % 2 == 0) ? 4'd0 : 4'd2;
      tick();
      $display("sat cmd %0d: rd=%0d out=%0d err=%b", i, s_rd, s_out, s_err);
      if (i == 14) chk("sat_rd_15", 64'(s_rd), 64'd15);
      if (i == 15) chk("sat_rd_hold", 64'(s_rd), 64'd15);
    end
    s_cmd_v = 1'b0;
    chk("sat_rd_final", 64'(s_rd),  64'd15);
    chk("sat_wr",       64'(s_wr),  64'd0);
    chk("sat_out",      64'(s_out), 64'd4);
    chk("sat_err",      64'(s_err), 64'd1);

    rst_s_n = 1'b0;
    tick();
    chk("s_rst_rd", 64'(s_rd), 64'd0);
    rst_s_n = 1'b1;

    // Timestamp wrap: stamp at 14, response at 3 -> latency 5.
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (s_ts == 14) found = 1;
      else tick();
    end
    chk("wrap_find_ts14", 64'(found), 64'd1);
    s_cmd_v = 1'b1; s_type = 4'd0;
    tick();
    s_cmd_v = 1'b0;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (s_ts == 3) found = 1;
      else tick();
    end
    chk("wrap_find_ts3", 64'(found), 64'd1);
    s_resp_v = 1'b1;
    tick();
    s_resp_v = 1'b0;
    $display("wrap resp: latv=%0d last=%0d max=%0d", s_latv, s_last, s_max);
    chk("wrap_latv", 64'(s_latv), 64'd1);
    chk("wrap_last", 64'(s_last), 64'd5);
    chk("wrap_max",  64'(s_max),  64'd5);
    chk("wrap_out",  64'(s_out),  64'd0);
    tick();
    chk("wrap_latv_pulse", 64'(s_latv), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
